// File: rtl/bf16_div_pkg.sv
// Shared bfloat16 types, constants and operand classification for the FPU units.
package fpu_bf16_pkg;

   localparam logic [15:0] BF16_QNAN = 16'h7FC0;
   localparam logic [14:0] BF16_PINF = 15'h7F80;
   localparam int unsigned BF16_BIAS = 127;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] man;
   } bf16_t;

   typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} bf16_class_e;

   // Subnormals classify as zero (denormals-are-zero).
   function automatic bf16_class_e bf16_classify(input bf16_t x);
      if (x.exp == 8'hFF) begin
         return (x.man != 7'd0) ? NAN : INF;
      end
      if (x.exp == 8'h00) begin
         return ZERO;
      end
      return NORMAL;
   endfunction

endpackage

// File: rtl/bf16_div_if.sv
// Operand/result handshake bundle of the bf16 divider.
interface bf16_div_if;

   logic        valid_i;
   logic        ready_o;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic        valid_o;
   logic        ready_i;
   logic [15:0] c_o;

   modport master (
      output valid_i, a_i, b_i, ready_i,
      input  ready_o, valid_o, c_o
   );

   modport slave (
      input  valid_i, a_i, b_i, ready_i,
      output ready_o, valid_o, c_o
   );

endinterface

// File: rtl/bf16_div_round.sv
// Normalize, round and range-check a raw restoring-division quotient into a bf16 result.
module bf16_div_round
   import fpu_bf16_pkg::*;
#(
   parameter bit RNE = 1'b1
) (
   input  logic              sign,
   input  logic signed [9:0] exp,
   input  logic [9:0]        q,
   input  logic [8:0]        rem,
   output logic [15:0]       res
);

   logic [6:0]        man;
   logic [7:0]        man_r;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic signed [9:0] exp_n;
   logic signed [9:0] exp_r;

   always_comb begin
      man      = 7'd0;
      guard    = 1'b0;
      sticky   = 1'b0;
      exp_n    = exp;
      if (q[9]) begin
         man    = q[8:2];
         guard  = q[1];
         sticky = q[0] | (rem != 9'd0);
      end else begin
         man    = q[7:1];
         guard  = q[0];
         sticky = (rem != 9'd0);
         exp_n  = exp - 10'sd1;
      end

      round_up = RNE && guard && (sticky || man[0]);
      man_r    = {1'b0, man} + {7'd0, round_up};
      // A carry out of the mantissa leaves man_r[6:0] at zero; only the exponent moves.
      exp_r    = man_r[7] ? exp_n + 10'sd1 : exp_n;

      if (exp_r >= 10'sd255) begin
         res = {sign, BF16_PINF};
      end else if (exp_r <= 10'sd0) begin
         res = 16'h0000;
      end else begin
         res = {sign, exp_r[7:0], man_r[6:0]};
      end
   end

endmodule

// File: rtl/bf16_div.sv
// Iterative bfloat16 divider: one restoring quotient bit per cycle, valid/ready on both sides.
module bf16_div
   import fpu_bf16_pkg::*;
#(
   parameter bit RNE = 1'b1
) (
   input logic        clk_i,
   input logic        rst_ni,
   bf16_div_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

   state_e            state_q;
   logic [8:0]        rem_q;
   logic [7:0]        div_q;
   logic [9:0]        q_q;
   logic signed [9:0] exp_q;
   logic              sign_q;
   logic [3:0]        cnt_q;
   logic [15:0]       c_q;
   logic              valid_q;
   logic              ready_q;

   bf16_t       a;
   bf16_t       b;
   bf16_class_e cls_a;
   bf16_class_e cls_b;
   logic        sign;
   logic        special;
   logic [15:0] special_res;
   logic        rem_ge;
   logic [8:0]  rem_sub;
   logic [8:0]  rem_nxt;
   logic [15:0] round_res;

   assign a     = bus.a_i;
   assign b     = bus.b_i;
   assign cls_a = bf16_classify(a);
   assign cls_b = bf16_classify(b);
   assign sign  = a.sign ^ b.sign;

   // First matching rule wins.
   always_comb begin
      special     = 1'b1;
      special_res = 16'h0000;
      if (cls_a == NAN || cls_b == NAN) begin
         special_res = BF16_QNAN;
      end else if (cls_a == INF && cls_b == INF) begin
         special_res = BF16_QNAN;
      end else if (cls_a == ZERO && cls_b == ZERO) begin
         special_res = BF16_QNAN;
      end else if (cls_a == INF || cls_b == ZERO) begin
         special_res = {sign, BF16_PINF};
      end else if (cls_b == INF || cls_a == ZERO) begin
         special_res = 16'h0000;
      end else begin
         special = 1'b0;
      end
   end

   assign rem_ge  = rem_q >= {1'b0, div_q};
   assign rem_sub = rem_q - {1'b0, div_q};
   assign rem_nxt = (rem_ge ? rem_sub : rem_q) << 1;

   bf16_div_round #(
      .RNE (RNE)
   ) u_round (
      .sign (sign_q),
      .exp  (exp_q),
      .q    (q_q),
      .rem  (rem_q),
      .res  (round_res)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         rem_q   <= 9'd0;
         div_q   <= 8'd0;
         q_q     <= 10'd0;
         exp_q   <= 10'sd0;
         sign_q  <= 1'b0;
         cnt_q   <= 4'd0;
         c_q     <= 16'h0000;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.valid_i && ready_q) begin
                  ready_q <= 1'b0;
                  sign_q  <= sign;
                  if (special) begin
                     c_q     <= special_res;
                     valid_q <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     rem_q   <= {2'b01, a.man};
                     div_q   <= {1'b1, b.man};
                     exp_q   <= 10'(a.exp) - 10'(b.exp) + 10'(BF16_BIAS);
                     q_q     <= 10'd0;
                     cnt_q   <= 4'd0;
                     state_q <= StDiv;
                  end
               end
            end
            StDiv: begin
               rem_q <= rem_nxt;
               q_q   <= {q_q[8:0], rem_ge};
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd9) begin
                  state_q <= StNorm;
               end
            end
            StNorm: begin
               c_q     <= round_res;
               valid_q <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               if (bus.ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.valid_o = valid_q;
   assign bus.c_o     = c_q;

endmodule

// File: tb/tb_bf16_div.sv
// Randomized self-checking bench for bf16_div against an integer-arithmetic reference model.
module tb_bf16_div;

   logic clk_i;
   logic rst_ni;
   int   checks;
   int   errors;

   bf16_div_if bus ();

   bf16_div #(
      .RNE (1'b1)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Correctly rounded (RNE) quotient with DAZ/FTZ, computed by integer long division.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] c, output bit special);
      int  ea, eb, ma, mb, na, nb, e, qt, rm, m;
      bit  s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      ma = int'(a[6:0]);
      mb = int'(b[6:0]);
      s  = a[15] ^ b[15];
      a_nan  = (ea == 255) && (ma != 0);
      b_nan  = (eb == 255) && (mb != 0);
      a_inf  = (ea == 255) && (ma == 0);
      b_inf  = (eb == 255) && (mb == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      special = 1'b1;
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) c = 16'h7FC0;
      else if (a_inf || b_zero) c = {s, 15'h7F80};
      else if (b_inf || a_zero) c = 16'h0000;
      else begin
         special = 1'b0;
         na = 128 + ma;
         nb = 128 + mb;
         e  = ea - eb + 127;
         if (na >= nb) begin
            qt = (na * 256) / nb;
            rm = (na * 256) % nb;
         end else begin
            qt = (na * 512) / nb;
            rm = (na * 512) % nb;
            e  = e - 1;
         end
         m = qt / 2;
         if ((qt % 2 == 1) && (rm != 0 || (m % 2 == 1))) m = m + 1;
         if (m == 256) begin
            m = 128;
            e = e + 1;
         end
         if (e >= 255) c = {s, 15'h7F80};
         else if (e <= 0) c = 16'h0000;
         else c = {s, 8'(e), 7'(m)};
      end
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c_exp,
                         input int edge_exp, input int hold);
      int k;
      bit rdy_seen;
      @(negedge clk_i);
      check("ready_idle", 32'(bus.ready_o), 32'd1);
      bus.valid_i = 1'b1;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      bus.valid_i = 1'b0;
      bus.a_i     = 16'($urandom);
      bus.b_i     = 16'($urandom);
      k = 0;
      rdy_seen = 1'b0;
      while (!bus.valid_o && k < 40) begin
         if (bus.ready_o) rdy_seen = 1'b1;
         @(posedge clk_i);
         #1;
         k++;
      end
      check("valid_edge", 32'(k), 32'(edge_exp));
      check("ready_busy", 32'(rdy_seen), 32'd0);
      check("result", 32'(bus.c_o), 32'(c_exp));
      for (int i = 0; i < hold; i++) begin
         bus.valid_i = i[0];
         bus.a_i     = 16'($urandom);
         bus.b_i     = 16'($urandom);
         @(posedge clk_i);
         #1;
         check("hold_valid", 32'(bus.valid_o), 32'd1);
         check("hold_c", 32'(bus.c_o), 32'(c_exp));
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.ready_i = 1'b0;
      check("ack_ready", 32'(bus.ready_o), 32'd1);
      check("ack_valid", 32'(bus.valid_o), 32'd0);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      int          lat;
   } vec_t;

   vec_t dir[] = '{
      '{16'h3F80, 16'h3F80, 16'h3F80, 11}, '{16'h40C0, 16'h4000, 16'h4040, 11},
      '{16'h3F80, 16'h4040, 16'h3EAB, 11}, '{16'h3F80, 16'hC040, 16'hBEAB, 11},
      '{16'hC000, 16'h0000, 16'hFF80, 0},  '{16'h0000, 16'h0000, 16'h7FC0, 0},
      '{16'h7F80, 16'h7F80, 16'h7FC0, 0},  '{16'h7FC1, 16'h3F80, 16'h7FC0, 0},
      '{16'h3F80, 16'h7F80, 16'h0000, 0},  '{16'h0001, 16'h3F80, 16'h0000, 0},
      '{16'h7F00, 16'h3E80, 16'h7F80, 11}, '{16'h0080, 16'h4000, 16'h0000, 11},
      '{16'h3FFF, 16'h3F81, 16'h3FFD, 11}
   };

   logic [15:0] pool[6] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h0005};

   function automatic logic [15:0] rand_operand();
      if ($urandom_range(7) == 0) return pool[$urandom_range(5)];
      return 16'($urandom);
   endfunction

   initial begin
      logic [15:0] ra, rb, rc;
      bit          sp;
      checks      = 0;
      errors      = 0;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.a_i     = 16'h0000;
      bus.b_i     = 16'h0000;
      rst_ni      = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", 32'(bus.valid_o), 32'd0);
      check("rst_c", 32'(bus.c_o), 32'd0);
      check("rst_ready", 32'(bus.ready_o), 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;

      foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].c, dir[i].lat, 0);

      // Backpressure in DONE with stray valid_i pulses.
      run_op(16'h4000, 16'h3F80, 16'h4000, 11, 5);

      // Abort mid-division.
      @(negedge clk_i);
      bus.valid_i = 1'b1;
      bus.a_i     = 16'h40C0;
      bus.b_i     = 16'h4000;
      @(posedge clk_i);
      #1;
      bus.valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      check("abort_valid", 32'(bus.valid_o), 32'd0);
      check("abort_c", 32'(bus.c_o), 32'd0);
      check("abort_ready", 32'(bus.ready_o), 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_op(16'h40C0, 16'h4000, 16'h4040, 11, 0);

      for (int n = 0; n < 300; n++) begin
         ra = rand_operand();
         rb = rand_operand();
         ref_div(ra, rb, rc, sp);
         run_op(ra, rb, rc, sp ? 0 : 11, int'($urandom_range(2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
